// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, line-level framing constants
// and the baud divider calculation used by both receiver and transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Clock cycles per oversample tick, truncated.
    function automatic int unsigned DIV(input int unsigned clk_freq,
                                        input int unsigned baud,
                                        input int unsigned oversample);
        return clk_freq / (baud * oversample);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Free-running divider emitting a one-cycle tick every DIV_VAL clocks;
// clr restarts the period so the next tick lands DIV_VAL cycles later.
module uart_rx_tick #(
    parameter int unsigned DIV_VAL = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV_VAL > 1) ? $clog2(DIV_VAL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_VAL - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear on request or at end of period.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST) && !clr;

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: 2-flop synchronizer, 16x oversampling with a
// 3-sample majority vote per bit, start/stop validation and strobed outputs.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 RST_clk,
    input  logic                 RST,
    input  logic                 uart_rx_data,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 uart_busy
);

    localparam int unsigned TICK_DIV = DIV(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [SW-1:0]        samp_q, samp_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 smp_lo_q, smp_lo_d;
    logic                 smp_mid_q, smp_mid_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q, busy_d;
    logic                 rx_s;
    logic                 vote_s;
    logic                 tick_s;
    logic                 clr_s;

    assign rx_s   = sync_q[1];
    assign vote_s = maj3(smp_lo_q, smp_mid_q, rx_s);

    uart_rx_tick #(
        .DIV_VAL (TICK_DIV)
    ) u_tick (
        .clk  (RST_clk),
        .rst  (RST),
        .clr  (clr_s),
        .tick (tick_s)
    );

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge RST_clk) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            sync_q    <= 2'b11;
            samp_q    <= '0;
            bit_q     <= '0;
            smp_lo_q  <= 1'b1;
            smp_mid_q <= 1'b1;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            samp_q    <= samp_d;
            bit_q     <= bit_d;
            smp_lo_q  <= smp_lo_d;
            smp_mid_q <= smp_mid_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic; decisions are taken on the tick that carries sample OS/2+1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_s == START_BIT) state_d = ST_START;
                else                   state_d = ST_IDLE;
            end
            ST_START: begin
                if (tick_s && (samp_q == S_HI) && (vote_s != START_BIT)) state_d = ST_IDLE;
                else if (tick_s && (samp_q == S_LAST))                    state_d = ST_DATA;
                else                                                      state_d = ST_START;
            end
            ST_DATA: begin
                if (tick_s && (samp_q == S_LAST) && (bit_q == B_LAST)) state_d = ST_STOP;
                else                                                   state_d = ST_DATA;
            end
            ST_STOP: begin
                if (tick_s && (samp_q == S_HI)) begin
                    state_d = (vote_s == STOP_BIT) ? ST_IDLE : ST_WAIT_HIGH;
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s == STOP_BIT) state_d = ST_IDLE;
                else                  state_d = ST_WAIT_HIGH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and strobes; busy follows the next state so it is low in the strobe cycle.
    always_comb begin
        sync_d    = {sync_q[0], uart_rx_data};
        samp_d    = samp_q;
        bit_d     = bit_q;
        smp_lo_d  = smp_lo_q;
        smp_mid_d = smp_mid_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        clr_s     = 1'b0;
        busy_d    = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE, ST_WAIT_HIGH: begin
                samp_d = '0;
                bit_d  = '0;
                clr_s  = (state_q == ST_IDLE) && (rx_s == START_BIT);
            end
            ST_START, ST_DATA, ST_STOP: begin
                if (tick_s) begin
                    samp_d = (samp_q == S_LAST) ? '0 : samp_q + SW'(1);
                    if (samp_q == S_LO)  smp_lo_d  = rx_s;
                    else                 smp_lo_d  = smp_lo_q;
                    if (samp_q == S_MID) smp_mid_d = rx_s;
                    else                 smp_mid_d = smp_mid_q;
                    if ((state_q == ST_DATA) && (samp_q == S_HI)) begin
                        shift_d = {vote_s, shift_q[DATA_BITS-1:1]};
                    end else begin
                        shift_d = shift_q;
                    end
                    if ((state_q == ST_DATA) && (samp_q == S_LAST)) bit_d = bit_q + BW'(1);
                    else                                           bit_d = bit_q;
                    if ((state_q == ST_STOP) && (samp_q == S_HI)) begin
                        valid_d = (vote_s == STOP_BIT);
                        ferr_d  = (vote_s != STOP_BIT);
                        data_d  = (vote_s == STOP_BIT) ? shift_q : data_q;
                    end else begin
                        valid_d = 1'b0;
                        ferr_d  = 1'b0;
                        data_d  = data_q;
                    end
                end else begin
                    samp_d = samp_q;
                end
            end
            default: begin
                samp_d = '0;
                bit_d  = '0;
            end
        endcase
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign uart_busy    = busy_q;

endmodule
